// File: rtl/scratchpad_lsu_pkg.sv
// Shared encodings for the scratchpad load/store unit: access sizes, FSM states
// and the byte-lane strobe helper.
package scratchpad_lsu_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  // Lane strobes for a store; the misaligned low bits are simply ignored here.
  function automatic logic [LANES-1:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/scratchpad_lsu_if.sv
// CPU-side request/response channel of the scratchpad load/store unit.
// The master modport is the pipeline, the slave modport is the LSU.
interface scratchpad_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/scratchpad_lsu_load_align.sv
// Combinational load path: picks the addressed byte/half lane out of a RAM
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import scratchpad_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    byte_sign = byte_lane[7] & ~is_unsigned;
    half_sign = half_lane[15] & ~is_unsigned;
    case (size)
      SZ_BYTE: data = {{24{byte_sign}}, byte_lane};
      SZ_HALF: data = {{16{half_sign}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/scratchpad_lsu.sv
// Scratchpad load/store unit: stores commit in the accept cycle, loads return
// two cycles after accept. Define SCRATCHPAD_LSU_ALIGN_CHECK_EN to fault misaligned accesses.
module scratchpad_lsu
  import scratchpad_lsu_pkg::*;
#(
  parameter int          BITS         = 32,
  parameter int          ADDRESS_BITS = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  scratchpad_lsu_if.slave         bus,
  output logic [ADDRESS_BITS-1:0] ram_rd_addr,
  output logic [ADDRESS_BITS-1:0] ram_wr_addr,
  output logic [BITS-1:0]         ram_wdata,
  output logic                    ram_WRb,
  output logic [LANES-1:0]        ram_wstrb,
  input  logic [BITS-1:0]         ram_rdata
);

  state_e      state;
  logic [31:0] offset;
  logic        in_range;
  logic        misaligned;
  logic        fault;
  logic        accept;
  logic        store_go;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        ld_fault;
  logic [31:0] load_data;

  // Addresses below the base wrap to a huge offset, so one compare covers both ends.
  assign offset   = bus.req_addr - BASE_ADDR;
  assign in_range = (offset[31:ADDRESS_BITS+2] == '0);

`ifdef SCRATCHPAD_LSU_ALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == SZ_HALF) && offset[0]) ||
                      ((bus.req_size == SZ_WORD) && (offset[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign fault         = !in_range || (bus.req_size == SZ_RSVD) || misaligned;
  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign store_go      = accept && bus.req_we && !fault && RSTb;

  assign ram_rd_addr = offset[ADDRESS_BITS+1:2];
  assign ram_wr_addr = offset[ADDRESS_BITS+1:2];
  assign ram_WRb     = !store_go;
  assign ram_wstrb   = store_go ? lane_strobe(bus.req_size, offset[1:0]) : '0;

  always_comb begin
    case (bus.req_size)
      SZ_BYTE: ram_wdata = {4{bus.req_wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{bus.req_wdata[15:0]}};
      default: ram_wdata = bus.req_wdata;
    endcase
  end

  lsu_load_align u_align (
    .rdata       (ram_rdata),
    .offset      (ld_off),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .data        (load_data)
  );

  // Store responses leave from IDLE one cycle after accept; loads detour through RD_WAIT.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state          <= ST_IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      ld_off         <= '0;
      ld_size        <= '0;
      ld_unsigned    <= 1'b0;
      ld_fault       <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.req_we) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= fault;
            end else begin
              ld_off      <= offset[1:0];
              ld_size     <= bus.req_size;
              ld_unsigned <= bus.req_unsigned;
              ld_fault    <= fault;
              state       <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= ld_fault;
          bus.resp_rdata <= ld_fault ? '0 : load_data;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_lsu.sv
// Directed, table-driven bench for scratchpad_lsu with a behavioural RAM model;
// expectations switch on SCRATCHPAD_LSU_ALIGN_CHECK_EN where the builds differ.
module tb_scratchpad_lsu;
  import scratchpad_lsu_pkg::*;

  logic        CLK;
  logic        RSTb;
  logic [9:0]  ram_rd_addr;
  logic [9:0]  ram_wr_addr;
  logic [31:0] ram_wdata;
  logic        ram_WRb;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  scratchpad_lsu_if bus ();

  scratchpad_lsu #(
    .BITS         (32),
    .ADDRESS_BITS (10),
    .BASE_ADDR    (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .bus         (bus),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_addr (ram_wr_addr),
    .ram_wdata   (ram_wdata),
    .ram_WRb     (ram_WRb),
    .ram_wstrb   (ram_wstrb),
    .ram_rdata   (ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered-read RAM with byte-lane writes.
  always @(posedge CLK) begin
    if (!ram_WRb) begin
      for (int i = 0; i < 4; i++)
        if (ram_wstrb[i]) mem[ram_wr_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    ram_rdata <= mem[ram_rd_addr];
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
    vecs.push_back(v);
  endtask

  // Called right after a negedge; returns on the negedge the response was seen.
  task automatic applyStimulus(input int idx, input vec_t v);
    int wait_n;
    int lat;
    logic [9:0] exp_word;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 10) begin
      @(negedge CLK);
      wait_n++;
    end
    checkOutput($sformatf("v%0d.ready", idx), bus.req_ready, 1'b1);
    exp_word = v.addr[11:2];
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    #1;
    checkOutput($sformatf("v%0d.WRb", idx), ram_WRb, (v.exp_strb == 4'b0000));
    checkOutput($sformatf("v%0d.wstrb", idx), ram_wstrb, v.exp_strb);
    checkOutput($sformatf("v%0d.rd_addr", idx), ram_rd_addr, exp_word);
    if (v.exp_strb != 4'b0000) begin
      checkOutput($sformatf("v%0d.wdata", idx), ram_wdata, v.exp_wdata);
      checkOutput($sformatf("v%0d.wr_addr", idx), ram_wr_addr, exp_word);
    end
    @(negedge CLK);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 6) begin
      @(negedge CLK);
      lat++;
    end
    checkOutput($sformatf("v%0d.latency", idx), lat, v.we ? 1 : 2);
    checkOutput($sformatf("v%0d.err", idx), bus.resp_err, v.exp_err);
    checkOutput($sformatf("v%0d.rdata", idx), bus.resp_rdata, v.exp_rdata);
  endtask

  initial begin
    int pulses;
    // we size uns addr wdata | err rdata strb wdata
    addVec(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'hF, 32'hDEADBEEF);
    addVec(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 4'h0, 32'h0);
    addVec(1, SZ_BYTE, 0, 32'h13, 32'h00000080, 0, 32'h0, 4'h8, 32'h80808080);
    addVec(0, SZ_BYTE, 0, 32'h13, 32'h0, 0, 32'hFFFFFF80, 4'h0, 32'h0);
    addVec(0, SZ_BYTE, 1, 32'h13, 32'h0, 0, 32'h00000080, 4'h0, 32'h0);
    addVec(1, SZ_HALF, 0, 32'h12, 32'h00001234, 0, 32'h0, 4'hC, 32'h12341234);
    addVec(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'h1234BEEF, 4'h0, 32'h0);
    addVec(0, SZ_WORD, 0, 32'h1000, 32'h0, 1, 32'h0, 4'h0, 32'h0);
    addVec(1, SZ_WORD, 0, 32'h20, 32'h11111111, 0, 32'h0, 4'hF, 32'h11111111);
    addVec(1, SZ_RSVD, 0, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 4'h0, 32'h0);
    addVec(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h11111111, 4'h0, 32'h0);
`ifdef SCRATCHPAD_LSU_ALIGN_CHECK_EN
    addVec(0, SZ_HALF, 1, 32'h11, 32'h0, 1, 32'h0, 4'h0, 32'h0);
`else
    addVec(0, SZ_HALF, 1, 32'h11, 32'h0, 0, 32'h0000BEEF, 4'h0, 32'h0);
`endif
    addVec(0, SZ_HALF, 0, 32'h12, 32'h0, 0, 32'h00001234, 4'h0, 32'h0);
    addVec(1, SZ_BYTE, 0, 32'h11, 32'h123456A5, 0, 32'h0, 4'h2, 32'hA5A5A5A5);
    addVec(0, SZ_BYTE, 0, 32'h11, 32'h0, 0, 32'hFFFFFFA5, 4'h0, 32'h0);
`ifdef SCRATCHPAD_LSU_ALIGN_CHECK_EN
    addVec(1, SZ_HALF, 0, 32'h13, 32'h0000CAFE, 1, 32'h0, 4'h0, 32'h0);
    addVec(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'h1234A5EF, 4'h0, 32'h0);
`else
    addVec(1, SZ_HALF, 0, 32'h13, 32'h0000CAFE, 0, 32'h0, 4'hC, 32'hCAFECAFE);
    addVec(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hCAFEA5EF, 4'h0, 32'h0);
`endif
    addVec(1, SZ_WORD, 0, 32'hFFC, 32'h0BADF00D, 0, 32'h0, 4'hF, 32'h0BADF00D);
    addVec(0, SZ_WORD, 0, 32'hFFC, 32'h0, 0, 32'h0BADF00D, 4'h0, 32'h0);
    addVec(0, SZ_BYTE, 0, 32'hFFE, 32'h0, 0, 32'hFFFFFFAD, 4'h0, 32'h0);
    addVec(1, SZ_BYTE, 0, 32'h1003, 32'h000000EE, 1, 32'h0, 4'h0, 32'h0);

    // Reset with a store request presented: RAM controls must stay gated.
    RSTb             = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'hFFFFFFFF;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst.WRb", ram_WRb, 1'b1);
    checkOutput("rst.wstrb", ram_wstrb, 4'h0);
    checkOutput("rst.ready", bus.req_ready, 1'b1);
    checkOutput("rst.resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst.resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst.resp_err", bus.resp_err, 1'b0);
    bus.req_valid = 1'b0;
    RSTb = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Store followed immediately by a load of the same word.
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_WORD;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h55AA33CC;
    @(negedge CLK);
    checkOutput("raw.store_resp", bus.resp_valid, 1'b1);
    bus.req_we = 1'b0;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    checkOutput("raw.wait_ready", bus.req_ready, 1'b0);
    @(negedge CLK);
    checkOutput("raw.load_resp", bus.resp_valid, 1'b1);
    checkOutput("raw.load_rdata", bus.resp_rdata, 32'h55AA33CC);

    // Four back-to-back stores must yield four response pulses.
    @(negedge CLK);
    @(negedge CLK);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid) pulses++;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_WORD;
      bus.req_addr = 32'h100 + 32'(4 * k); bus.req_wdata = 32'hA0 + 32'(k);
      #1;
      checkOutput($sformatf("b2b%0d.WRb", k), ram_WRb, 1'b0);
      @(negedge CLK);
    end
    if (bus.resp_valid) pulses++;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    if (bus.resp_valid) pulses++;
    checkOutput("b2b.pulses", pulses, 4);

    // Reset while a load waits in RD_WAIT: no response may escape.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_addr = 32'h104;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    checkOutput("midrst.rd_wait", bus.req_ready, 1'b0);
    RSTb = 1'b0;
    #1;
    checkOutput("midrst.ready", bus.req_ready, 1'b1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (bus.resp_valid) pulses++;
    end
    RSTb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      if (bus.resp_valid) pulses++;
    end
    checkOutput("midrst.pulses", pulses, 0);
    checkOutput("midrst.ready_after", bus.req_ready, 1'b1);
    checkOutput("midrst.rdata", bus.resp_rdata, 32'h0);
    checkOutput("midrst.err", bus.resp_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scratchpad_lsu.md
Name: scratchpad_lsu

Overview:
- Initiator-side load/store unit driving the scratchpad RAM's read, write and byte-strobe port.
- Accepts one byte, halfword or word request per handshake from the CPU pipeline.
- Generates the RAM's active-low write enable and lane strobes, and aligns store data to byte lanes.
- Captures registered RAM read data and returns aligned, sign- or zero-extended load results with an error flag.

Parameters:
BITS, 32, data width; fixed at 32 because there are 4 byte lanes.
ADDRESS_BITS, 10, RAM word-address width; the byte window is 4 << ADDRESS_BITS bytes.
BASE_ADDR, 32'h0000_0000, byte base address of the scratchpad window; must be window-aligned.

Ports:
CLK  in  1  clock.
RSTb  in  1  reset, asynchronous assert, active-low.
req_valid  in  1  request valid.
req_ready  out  1  request accept; high only in IDLE.
req_addr  in  32  byte address.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  32  load result; 0 for stores and errors.
resp_err  out  1  access fault, qualified by resp_valid.
ram_rd_addr  out  ADDRESS_BITS  RAM read word address.
ram_wr_addr  out  ADDRESS_BITS  RAM write word address.
ram_wdata  out  32  lane-replicated store data.
ram_WRb  out  1  RAM write enable, active-low.
ram_wstrb  out  4  byte-lane strobes.
ram_rdata  in  32  RAM registered read data, valid the cycle after ram_rd_addr is presented.

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
- While RSTb=0: ram_WRb=1 and ram_wstrb=0 (combinationally gated).
- Word address: ram_rd_addr = ram_wr_addr = (req_addr-BASE_ADDR)[ADDRESS_BITS+1:2]. Driven combinationally from req_addr in every state.
- Accept condition: req_valid & req_ready in cycle N.
- Fault conditions: address outside [BASE_ADDR, BASE_ADDR + 4<<ADDRESS_BITS), or req_size=11.
  - A faulting access never writes the RAM.
  - Its response follows the normal latency with resp_err=1 and resp_rdata=0.
- Store accepted in cycle N, no fault:
  - ram_WRb=0 in cycle N (combinational); the write lands at the end of N.
  - resp_valid=1 in N+1 with resp_err=0.
  - State stays IDLE, so back-to-back stores sustain 1 per cycle.
- Store lane mapping:
  - byte: ram_wdata = wdata[7:0] replicated x4; ram_wstrb = 1 << addr[1:0].
  - half: ram_wdata = wdata[15:0] replicated x2; ram_wstrb = 0011 if addr[1]=0, else 1100.
  - word: ram_wstrb = 1111.
- Load accepted in cycle N:
  - Latch addr[1:0], size, unsigned and the fault flag; go to RD_WAIT in N+1.
  - In N+1, ram_rdata is valid; register the extracted lane, then extend to 32 bits.
  - resp_valid=1 in N+2; return to IDLE in N+2, where req_ready=1 again.
  - Load latency is 2; issue rate is 1 load per 2 cycles.
- Store then load to the same word in consecutive accepts returns the new data, because the write commits before the read is sampled.
- States: IDLE -> RD_WAIT on an accepted load; RD_WAIT -> IDLE unconditionally.
- Reset mid-load: the pending load is dropped and no response is issued.
- Outside a store accept: ram_WRb=1 and ram_wstrb=0.

Optional Feature:
Macro SCRATCHPAD_LSU_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, faults (resp_err=1, no write).
- Undefined: misalignment is never flagged; offending low address bits are ignored (half uses addr[1] only, word uses lane 0). Range and size checks remain in both builds.

Decomposition:
- Package scratchpad_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - state encodings ST_IDLE/ST_RD_WAIT;
  - a lane-count constant.
- One natural sub-module: lsu_load_align, a combinational lane extract plus sign/zero extend taking ram_rdata, offset, size and unsigned.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> ram_WRb low one cycle, wstrb=1111, wr_addr=4; load resp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
- Store byte 0x80 @0x13, signed load byte @0x13 -> wstrb=1000, wdata=0x80808080; rdata=0xFFFFFF80; unsigned load -> 0x00000080.
- Store half 0x1234 @0x12, load word @0x10 -> wstrb=1100; rdata=0x1234BEEF.
- Load @0x1000 with ADDRESS_BITS=10 (out of range), and a size=11 store -> resp_err=1, rdata=0, no RAM write.
- With the macro: half load @0x11 -> err=1. Without it: same access returns the half at 0x10, err=0.
- Back-to-back stores for 4 cycles -> 4 resp pulses. Then assert RSTb low during RD_WAIT -> no resp_valid; after release, req_ready=1 and outputs hold their reset values.
